wb_stage_param: RTL and testbench

Parametrised write-back stage for the pipelined processor. It selects the register-file write value from NSRC result sources and qualifies the register write. It also replaces the single output-port latch with an OUT_DEPTH-entry output-port FIFO that uses a valid/ready handshake toward the I/O side. A stall output holds the pipeline when an OUT instruction reaches write-back while the FIFO is full.

---
 rtl/wb_stage_param.sv | 106 ++++++++++
 tb/tb_wb_stage_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_param.sv
// Write-back stage: NSRC-way result mux with register-write qualification,
// plus an OUT_DEPTH-entry output-port FIFO with a valid/ready drain side.
module wb_stage_param #(
    parameter int WIDTH     = 16,
    parameter int NSRC      = 4,
    parameter int SEL_W     = 3,
    parameter int AW        = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_valid,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NSRC*WIDTH-1:0]        src_data,
    input  logic                         reg_we_in,
    input  logic [AW-1:0]                reg_addr_in,
    input  logic                         outport_en,
    input  logic [WIDTH-1:0]             outport_data,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             wb_data,
    output logic                         wb_we,
    output logic [AW-1:0]                wb_addr,
    output logic                         stall,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(OUT_DEPTH):0]   out_level,
    output logic [WIDTH-1:0]             outport_last,
    output logic                         sel_err
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [SEL_W:0] NSRC_L = (SEL_W + 1)'(NSRC);
    localparam logic [LW-1:0]  FULL_L = LW'(OUT_DEPTH);

    logic [WIDTH-1:0] mem [OUT_DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [LW-1:0]    count;
    logic [WIDTH-1:0] last_val;
    logic             sel_err_q;
    logic             sel_ok;
    logic             full;
    logic             push;
    logic             pop;

    assign sel_ok = ({1'b0, sel} < NSRC_L);

    // Unmatched (out-of-range) selects fall through to the zero default.
    always_comb begin
        wb_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                wb_data = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Full is judged on the registered count only: no same-cycle bypass.
    assign full      = (count == FULL_L);
    assign stall     = wb_valid & outport_en & full;
    assign push      = wb_valid & outport_en & ~full;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    assign wb_we        = wb_valid & reg_we_in & sel_ok & ~stall;
    assign wb_addr      = reg_addr_in;
    assign out_data     = mem[rp];
    assign out_level    = count;
    assign outport_last = last_val;
    assign sel_err      = sel_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            last_val  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (push) begin
                wp       <= wp + PW'(1);
                last_val <= outport_data;
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (wb_valid & reg_we_in & ~sel_ok) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= outport_data;
        end
    end

endmodule

// File: tb/tb_wb_stage_param.sv
// Bench for wb_stage_param: directed scenarios plus random traffic checked
// against a queue-based reference model of the mux and output FIFO.
module tb_wb_stage_param;

    localparam int WIDTH     = 16;
    localparam int NSRC      = 5;
    localparam int SEL_W     = 3;
    localparam int AW        = 3;
    localparam int OUT_DEPTH = 4;
    localparam int LW        = $clog2(OUT_DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  wb_valid = 1'b0;
    logic [SEL_W-1:0]      sel = '0;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  reg_we_in = 1'b0;
    logic [AW-1:0]         reg_addr_in = '0;
    logic                  outport_en = 1'b0;
    logic [WIDTH-1:0]      outport_data = '0;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      wb_data;
    logic                  wb_we;
    logic [AW-1:0]         wb_addr;
    logic                  stall;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [LW-1:0]         out_level;
    logic [WIDTH-1:0]      outport_last;
    logic                  sel_err;

    logic [WIDTH-1:0] srcs [NSRC];

    always_comb begin
        src_data = '0;
        for (int k = 0; k < NSRC; k++) src_data[k*WIDTH +: WIDTH] = srcs[k];
    end

    wb_stage_param #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SEL_W(SEL_W), .AW(AW), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .sel(sel), .src_data(src_data),
        .reg_we_in(reg_we_in), .reg_addr_in(reg_addr_in), .outport_en(outport_en),
        .outport_data(outport_data), .out_ready(out_ready), .wb_data(wb_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .stall(stall), .out_valid(out_valid),
        .out_data(out_data), .out_level(out_level), .outport_last(outport_last),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_last = '0;
    logic             exp_sel_err = 1'b0;
    logic             last_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_regs();
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("out_level", 32'(out_level), 32'(exp_q.size()));
        chk("outport_last", 32'(outport_last), 32'(exp_last));
        chk("sel_err", 32'(sel_err), 32'(exp_sel_err));
        if (exp_q.size() != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    endtask

    // Drive one cycle of inputs, check combinational outputs, clock, check state.
    task automatic step(input logic v, input int s, input logic we, input logic oe,
                        input logic [WIDTH-1:0] od, input logic rdy);
        logic e_stall, e_push, e_pop;
        logic [WIDTH-1:0] e_wbd;
        wb_valid     = v;
        sel          = SEL_W'(s);
        reg_we_in    = we;
        reg_addr_in  = AW'($urandom);
        outport_en   = oe;
        outport_data = od;
        out_ready    = rdy;
        #1;
        e_stall = v && oe && (exp_q.size() == OUT_DEPTH);
        e_push  = v && oe && !e_stall;
        e_pop   = (exp_q.size() != 0) && rdy;
        e_wbd   = (s < NSRC) ? srcs[s] : '0;
        chk("wb_data", 32'(wb_data), 32'(e_wbd));
        chk("wb_we", 32'(wb_we), 32'(v && we && (s < NSRC) && !e_stall));
        chk("wb_addr", 32'(wb_addr), 32'(reg_addr_in));
        chk("stall", 32'(stall), 32'(e_stall));
        last_stall = e_stall;
        @(posedge clk);
        if (e_pop) void'(exp_q.pop_front());
        if (e_push) begin
            exp_q.push_back(od);
            exp_last = od;
        end
        if (v && we && s >= NSRC) exp_sel_err = 1'b1;
        #1;
        check_regs();
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_last    = '0;
        exp_sel_err = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_exp [4];
        logic        rv, rwe, roe, rrdy;
        int          rs;
        logic [WIDTH-1:0] rod;

        srcs[0] = 16'h1111; srcs[1] = 16'h2222; srcs[2] = 16'h3333;
        srcs[3] = 16'h4444; srcs[4] = 16'h5555;
        sweep_exp[0] = 16'h1111; sweep_exp[1] = 16'h2222;
        sweep_exp[2] = 16'h3333; sweep_exp[3] = 16'h4444;

        // Reset state
        #2;
        check_regs();
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_wb_we", 32'(wb_we), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Mux sweep
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; reg_we_in = 1'b1; outport_en = 1'b0; sel = SEL_W'(i);
            #1;
            chk("sweep_data", 32'(wb_data), 32'(sweep_exp[i]));
            chk("sweep_we", 32'(wb_we), 32'(1));
            step(1, i, 1, 0, '0, 0);
        end

        // Out-of-range select sets the sticky flag
        step(1, 6, 1, 0, '0, 0);
        chk("sel_err_set", 32'(sel_err), 32'(1));
        step(1, 1, 1, 0, '0, 0);
        step(1, 4, 1, 0, '0, 0);
        chk("sel_err_sticky", 32'(sel_err), 32'(1));

        // Fill and stall
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, WIDTH'(16'hA0 + i), 0);
        chk("fill_level", 32'(out_level), 32'(4));
        step(1, 1, 1, 1, 16'hA4, 0);
        step(1, 1, 1, 1, 16'hA4, 1);     // stalled, but the head pops
        chk("pop_level", 32'(out_level), 32'(3));
        step(1, 1, 1, 1, 16'hA4, 0);     // retry accepted
        chk("retry_level", 32'(out_level), 32'(4));
        chk("retry_last", 32'(outport_last), 32'(16'hA4));
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(out_data), 32'(16'hA1 + i));
            step(0, 0, 0, 0, '0, 1);
        end

        // Simultaneous push and pop at level 2, then streaming across the wrap
        step(1, 0, 0, 1, 16'hB0, 0);
        step(1, 0, 0, 1, 16'hB1, 0);
        step(1, 0, 0, 1, 16'hB2, 1);
        chk("pp_level", 32'(out_level), 32'(2));
        chk("pp_last", 32'(outport_last), 32'(16'hB2));
        for (int i = 0; i < 10; i++) step(1, 2, 1, 1, WIDTH'(16'hC0 + i), 1);
        chk("stream_head", 32'(out_data), 32'(16'hC8));

        // Random traffic; inputs are held while stalled
        rv = 0; rs = 0; rwe = 0; roe = 0; rod = '0; rrdy = 0;
        for (int n = 0; n < 300; n++) begin
            if (!last_stall) begin
                rv  = ($urandom_range(0, 3) != 0);
                rs  = $urandom_range(0, NSRC - 1);
                rwe = $urandom_range(0, 1) == 1;
                roe = $urandom_range(0, 1) == 1;
                rod = WIDTH'($urandom);
                if ($urandom_range(0, 7) == 0) srcs[$urandom_range(0, NSRC - 1)] = WIDTH'($urandom);
            end
            rrdy = $urandom_range(0, 2) == 0;
            step(rv, rs, rwe, roe, rod, rrdy);
        end

        // Bring level to exactly 3, then reset asynchronously mid-cycle
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, WIDTH'(16'hD0 + i), 0);
        chk("pre_reset_level", 32'(out_level), 32'(3));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_level", 32'(out_level), 32'(0));
        chk("arst_last", 32'(outport_last), 32'(0));
        chk("arst_sel_err", 32'(sel_err), 32'(0));
        wb_valid = 1'b0; outport_en = 1'b0; out_ready = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        step(1, 0, 0, 1, 16'h0055, 0);
        chk("post_reset_data", 32'(out_data), 32'(16'h0055));
        chk("post_reset_level", 32'(out_level), 32'(1));
        step(0, 0, 0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
